// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Sequences fixed-latency reads and done-handshaked, time-limited writes.
module mem_port_arbiter #(
  parameter int WORD_SIZE     = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_req,
  input  logic [WORD_SIZE-1:0] f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  output logic [WORD_SIZE-1:0] f_rdata,
  output logic                 f_err,
  input  logic                 d_req,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [1:0]           d_wsize,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_err,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [1:0]           mem_write,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_done,
  input  logic                 mem_error,
  output logic                 busy
);

  localparam int MAXC =
    (READ_LATENCY > WRITE_TIMEOUT) ? READ_LATENCY : WRITE_TIMEOUT;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] RL_M1 = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] TO_M1 = CW'(WRITE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, READ_WAIT, WRITE_WAIT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last_d, last_d_n;
  logic            cur_d, cur_d_n;
  logic            grant_f, grant_d;
  logic            d_is_wr, wr_end;

  logic                 f_gnt_n, f_rvalid_n, f_err_n;
  logic                 d_gnt_n, d_rvalid_n, d_err_n;
  logic [WORD_SIZE-1:0] f_rdata_n, d_rdata_n;
  logic [WORD_SIZE-1:0] mem_addr_n, mem_wdata_n;
  logic [1:0]           mem_write_n;

  // Ties go to the port that was not granted on the previous tie
  assign grant_f = f_req & (~d_req | last_d);
  assign grant_d = d_req & ~grant_f;
  assign d_is_wr = (d_wsize != 2'b00);
  assign wr_end  = mem_error | mem_done | (cnt == TO_M1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b1;
      cur_d  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      last_d <= last_d_n;
      cur_d  <= cur_d_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_d_n = last_d;
    cur_d_n  = cur_d;
    unique case (state)
      IDLE: begin
        if (f_req && d_req)
          last_d_n = grant_d;
        if (grant_f) begin
          state_n = READ_WAIT;
          cnt_n   = RL_M1;
          cur_d_n = 1'b0;
        end else if (grant_d) begin
          cur_d_n = 1'b1;
          if (d_is_wr) begin
            state_n = WRITE_WAIT;
            cnt_n   = '0;
          end else begin
            state_n = READ_WAIT;
            cnt_n   = RL_M1;
          end
        end
      end
      READ_WAIT: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      WRITE_WAIT: begin
        if (wr_end) state_n = IDLE;
        else        cnt_n   = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    f_gnt_n     = 1'b0;
    d_gnt_n     = 1'b0;
    f_rvalid_n  = 1'b0;
    d_rvalid_n  = 1'b0;
    f_rdata_n   = f_rdata;
    f_err_n     = f_err;
    d_rdata_n   = d_rdata;
    d_err_n     = d_err;
    mem_addr_n  = mem_addr;
    mem_write_n = mem_write;
    mem_wdata_n = mem_wdata;
    unique case (state)
      IDLE: begin
        if (grant_f) begin
          f_gnt_n     = 1'b1;
          mem_addr_n  = f_addr;
          mem_write_n = 2'b00;
        end else if (grant_d) begin
          d_gnt_n     = 1'b1;
          mem_addr_n  = d_addr;
          mem_write_n = 2'b00;
          if (d_is_wr) begin
            mem_write_n = d_wsize;
            mem_wdata_n = d_wdata;
          end
        end
      end
      READ_WAIT: begin
        if (cnt == '0) begin
          if (cur_d) begin
            d_rvalid_n = 1'b1;
            d_rdata_n  = mem_rdata;
            d_err_n    = mem_error;
          end else begin
            f_rvalid_n = 1'b1;
            f_rdata_n  = mem_rdata;
            f_err_n    = mem_error;
          end
        end
      end
      WRITE_WAIT: begin
        // Error wins over done; a timeout is reported as an error
        if (wr_end) begin
          mem_write_n = 2'b00;
          d_rvalid_n  = 1'b1;
          d_rdata_n   = '0;
          d_err_n     = mem_error | ~mem_done;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      f_rdata   <= '0;
      f_err     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_addr  <= '0;
      mem_write <= 2'b00;
      mem_wdata <= '0;
    end else begin
      f_gnt     <= f_gnt_n;
      d_gnt     <= d_gnt_n;
      f_rvalid  <= f_rvalid_n;
      d_rvalid  <= d_rvalid_n;
      f_rdata   <= f_rdata_n;
      f_err     <= f_err_n;
      d_rdata   <= d_rdata_n;
      d_err     <= d_err_n;
      mem_addr  <= mem_addr_n;
      mem_write <= mem_write_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule
